// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its downstream stages.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } operation_t;

  // Cycles from in_valid to out_valid; bounds how far rsv may run ahead of count.
  localparam int ALU_LATENCY       = 2;
  localparam int ALU_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. Accepts a push into a full FIFO when a pop
// happens in the same cycle. Storage is not reset; rd_data reads as 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             push,
  output logic             pop
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Handshake qualification and show-ahead head of queue.
  always_comb begin
    rd_valid = (count_q != '0);
    pop      = rd_valid & pop_req;
    push     = push_req & ((count_q < DEPTH_C) | pop);
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  end

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// Result buffer behind the 2-cycle alu. Tracks issued-but-unpopped operations
// in rsv so the issuer can be throttled via issue_ok, since the alu cannot stall.
// Optional statistics counters: define ALU_RESULT_BUFFER_STATS_EN.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_in,
  output logic             issue_ok,
  input  logic [WIDTH-1:0] res_in,
  input  logic             res_valid_in,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    count,
  output logic             overflow_err,
  output logic             issue_err,
  input  logic             clr_err
`ifdef ALU_RESULT_BUFFER_STATS_EN
  ,
  output logic [15:0]      stat_pushed,
  output logic [15:0]      stat_popped
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          push, pop, drop;
  logic [CW-1:0] rsv_q, rsv_d;
  logic          overflow_err_q, overflow_err_d;
  logic          issue_err_q, issue_err_d;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (res_valid_in),
    .wr_data  (res_in),
    .pop_req  (m_ready),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .count    (count),
    .push     (push),
    .pop      (pop)
  );

  // Reservation tracking and sticky error next-state; a set beats clr_err.
  always_comb begin
    issue_ok = (rsv_q < DEPTH_C);
    drop     = res_valid_in & ~push;
    rsv_d    = rsv_q;
    if (issue_in & ~pop) begin
      if (issue_ok) rsv_d = rsv_q + 1'b1;
    end else if (pop & ~issue_in) begin
      if (rsv_q != '0) rsv_d = rsv_q - 1'b1;
    end
    overflow_err_d = drop | (overflow_err_q & ~clr_err);
    issue_err_d    = (issue_in & ~issue_ok) | (issue_err_q & ~clr_err);
  end

  // Reservation counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_q          <= '0;
      overflow_err_q <= 1'b0;
      issue_err_q    <= 1'b0;
    end else begin
      rsv_q          <= rsv_d;
      overflow_err_q <= overflow_err_d;
      issue_err_q    <= issue_err_d;
    end
  end

  assign overflow_err = overflow_err_q;
  assign issue_err    = issue_err_q;

`ifdef ALU_RESULT_BUFFER_STATS_EN
  logic [15:0] stat_pushed_q, stat_pushed_d;
  logic [15:0] stat_popped_q, stat_popped_d;

  // Saturating push/pop event counters.
  always_comb begin
    stat_pushed_d = stat_pushed_q;
    stat_popped_d = stat_popped_q;
    if (push && stat_pushed_q != 16'hFFFF) stat_pushed_d = stat_pushed_q + 16'd1;
    if (pop  && stat_popped_q != 16'hFFFF) stat_popped_d = stat_popped_q + 16'd1;
  end

  // Statistics registers, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pushed_q <= '0;
      stat_popped_q <= '0;
    end else begin
      stat_pushed_q <= stat_pushed_d;
      stat_popped_q <= stat_popped_d;
    end
  end

  assign stat_pushed = stat_pushed_q;
  assign stat_popped = stat_popped_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: a 2-cycle alu stand-in feeds the DUT, a queue
// model tracks expected outputs every cycle, and directed steps pin key values.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, issue_in = 1'b0, m_ready = 1'b0, clr_err = 1'b0;
  logic          inj_v = 1'b0;
  logic [W-1:0]  inj_d = '0;
  operation_t    op = OP_NOP;
  logic [W-1:0]  a = '0, b = '0;

  logic          issue_ok, m_valid, overflow_err, issue_err;
  logic [W-1:0]  m_data, res_in;
  logic          res_valid_in;
  logic [CW-1:0] count;
`ifdef ALU_RESULT_BUFFER_STATS_EN
  logic [15:0]   stat_pushed, stat_popped;
`endif

  alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_in     (issue_in),
    .issue_ok     (issue_ok),
    .res_in       (res_in),
    .res_valid_in (res_valid_in),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .overflow_err (overflow_err),
    .issue_err    (issue_err),
    .clr_err      (clr_err)
`ifdef ALU_RESULT_BUFFER_STATS_EN
    ,
    .stat_pushed  (stat_pushed),
    .stat_popped  (stat_popped)
`endif
  );

  // Two-stage alu stand-in; inj_* lets the bench push a result with no issue.
  function automatic logic [W-1:0] alu_f(operation_t o, logic [W-1:0] x, logic [W-1:0] y);
    case (o)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      default: return '0;
    endcase
  endfunction

  logic         s1_v = 1'b0, s2_v = 1'b0;
  logic [W-1:0] s1_d = '0, s2_d = '0;
  always @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= issue_in;
      s1_d <= alu_f(op, a, b);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign res_valid_in = s2_v | inj_v;
  assign res_in       = inj_v ? inj_d : s2_d;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  function automatic void cmp(string n, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of results plus an outstanding-op count.
  logic [W-1:0] q[$];
  int rsv_m = 0;
  bit ovf_m = 1'b0, ierr_m = 1'b0;
  always @(posedge clk) begin
    bit pop_m, push_m, oset, iset;
    if (rst) begin
      q.delete();
      rsv_m  = 0;
      ovf_m  = 1'b0;
      ierr_m = 1'b0;
    end else begin
      pop_m  = (q.size() != 0) && m_ready;
      push_m = res_valid_in && (q.size() < D || pop_m);
      oset   = res_valid_in && !push_m;
      iset   = issue_in && !(rsv_m < D);
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(res_in);
      if (issue_in && !pop_m) rsv_m = (rsv_m < D) ? rsv_m + 1 : D;
      else if (pop_m && !issue_in && rsv_m > 0) rsv_m = rsv_m - 1;
      ovf_m  = oset || (ovf_m && !clr_err);
      ierr_m = iset || (ierr_m && !clr_err);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_valid", int'(m_valid), int'(q.size() != 0));
      if (q.size() != 0) cmp("m_data", int'(m_data), int'(q[0]));
      cmp("count", int'(count), q.size());
      cmp("issue_ok", int'(issue_ok), int'(rsv_m < D));
      cmp("overflow_err", int'(overflow_err), int'(ovf_m));
      cmp("issue_err", int'(issue_err), int'(ierr_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(operation_t o, logic [W-1:0] x, logic [W-1:0] y);
    issue_in = 1'b1; op = o; a = x; b = y;
    tick();
    issue_in = 1'b0;
  endtask

  initial begin
    int npop, nis;
    bit seen;
    // Reset state
    tick(); tick();
    chk_en = 1'b1;
    cmp("rst_count", int'(count), 0);
    cmp("rst_m_valid", int'(m_valid), 0);
    cmp("rst_m_data", int'(m_data), 0);
    cmp("rst_issue_ok", int'(issue_ok), 1);
    cmp("rst_errs", int'({overflow_err, issue_err}), 0);
    rst = 1'b0;

    // Basic: 3+4 -> 7, popped immediately
    m_ready = 1'b1;
    issue(OP_ADD, 8'd3, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = m_valid;
    end
    cmp("basic_seen", int'(seen), 1);
    cmp("basic_data", int'(m_data), 8'h07);
    tick();
    cmp("basic_count", int'(count), 0);
    cmp("basic_issue_ok", int'(issue_ok), 1);

    // Fill with 1..4, then drain in order
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue(OP_ADD, 8'(i), 8'd0);
    cmp("fill_issue_ok", int'(issue_ok), 0);
    tick(); tick();
    cmp("fill_count", int'(count), 4);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cmp("fill_order", int'(m_data), i);
      tick();
      if (i == 1) cmp("fill_issue_ok_after_pop", int'(issue_ok), 1);
    end
    m_ready = 1'b0;

    // Push and pop together while full
    for (int i = 5; i <= 8; i++) issue(OP_ADD, 8'(i), 8'd0);
    tick(); tick();
    cmp("full_count", int'(count), 4);
    inj_v = 1'b1; inj_d = 8'd9; m_ready = 1'b1;
    tick();
    inj_v = 1'b0;
    cmp("full_count_hold", int'(count), 4);
    cmp("full_no_ovf", int'(overflow_err), 0);
    for (int i = 6; i <= 9; i++) begin
      cmp("full_order", int'(m_data), i);
      tick();
    end
    m_ready = 1'b0;
    cmp("full_empty", int'(m_valid), 0);

    // Protocol violation; clr_err in the same cycle loses to the set
    for (int i = 0; i < 4; i++) issue(OP_SUB, 8'd20, 8'(i));
    tick(); tick();
    cmp("viol_count", int'(count), 4);
    clr_err = 1'b1;
    issue(OP_ADD, 8'hAA, 8'h00);
    clr_err = 1'b0;
    cmp("viol_issue_err", int'(issue_err), 1);
    tick(); tick();
    cmp("viol_overflow_err", int'(overflow_err), 1);
    cmp("viol_count_hold", int'(count), 4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    cmp("clr_errs", int'({overflow_err, issue_err}), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp("viol_drain", int'(m_data), 20 - i);
      tick();
    end
    m_ready = 1'b0;
    cmp("viol_issue_ok", int'(issue_ok), 1);

    // Wrap-around stream 0x10..0x19 with m_ready toggling
    npop = 0; nis = 0;
    for (int c = 0; c < 80 && npop < 10; c++) begin
      m_ready = c[0];
      if (m_valid && m_ready) begin
        cmp("wrap_order", int'(m_data), 'h10 + npop);
        npop++;
      end
      if (nis < 10 && rsv_m < D) begin
        issue_in = 1'b1; op = OP_ADD; a = 8'(8'h10 + nis); b = 8'd0;
        nis++;
      end
      tick();
      issue_in = 1'b0;
    end
    m_ready = 1'b0;
    cmp("wrap_all_popped", npop, 10);
    cmp("wrap_errs", int'({overflow_err, issue_err}), 0);

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) issue(OP_ADD, 8'(i), 8'd1);
    tick(); tick();
    cmp("midrst_count_before", int'(count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("midrst_count", int'(count), 0);
    cmp("midrst_m_valid", int'(m_valid), 0);
    cmp("midrst_issue_ok", int'(issue_ok), 1);
    cmp("midrst_errs", int'({overflow_err, issue_err}), 0);
    tick(); tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
